piso_serializer: RTL

- Parallel-in, serial-out transmitter: the other end of our serial-in per-bit shift chains.
- Accepts one DATA_WIDTH word per valid/ready handshake and drives it out MSB-first, one bit per i_shift_en strobe.
- Provides frame markers (first bit, last bit) for the downstream receiver.
- A one-word hold buffer allows gapless back-to-back words.

---
 rtl/piso_serializer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter, MSB first, with frame markers.
// Optional macro PISO_PARITY_EN appends an even-parity bit to each frame.
module piso_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_shift_en,
  input  logic                  i_data_vld,
  output logic                  o_data_rdy,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  output logic                  o_ser_data,
  output logic                  o_ser_vld,
  output logic                  o_ser_sof,
  output logic                  o_ser_eof,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  rdy_q, rdy_d;
  logic                  load;
`ifdef PISO_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    load        = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d    = parity_q;
`endif

    if (i_shift_en) begin
      case (state_q)
        ST_IDLE: begin
          if (hold_full_q) load = 1'b1;
        end
        ST_SHIFT: begin
          if (cnt_q != '0) begin
            shreg_d = shreg_q << 1;
            cnt_d   = cnt_q - CNT_WIDTH'(1);
          end else begin
`ifdef PISO_PARITY_EN
            state_d = ST_PARITY;
`else
            if (hold_full_q) load = 1'b1;
            else             state_d = ST_IDLE;
`endif
          end
        end
        ST_PARITY: begin
          if (hold_full_q) load = 1'b1;
          else             state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (load) begin
      shreg_d     = hold_q;
      cnt_d       = LAST_CNT;
      hold_full_d = 1'b0;
      state_d     = ST_SHIFT;
`ifdef PISO_PARITY_EN
      parity_d    = ^hold_q;
`endif
    end

    // A load and an accept never coincide: rdy_q is low whenever the hold is full.
    if (i_data_vld && rdy_q) begin
      hold_d      = i_data_in;
      hold_full_d = 1'b1;
    end

    rdy_d = ~hold_full_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      rdy_q       <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      rdy_q       <= rdy_d;
`ifdef PISO_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign o_data_rdy = rdy_q;
  assign o_ser_vld  = (state_q != ST_IDLE);
  assign o_ser_sof  = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
  assign o_busy     = (state_q != ST_IDLE) || hold_full_q;
`ifdef PISO_PARITY_EN
  assign o_ser_data = ((state_q == ST_SHIFT) && shreg_q[DATA_WIDTH-1]) ||
                      ((state_q == ST_PARITY) && parity_q);
  assign o_ser_eof  = (state_q == ST_PARITY);
`else
  assign o_ser_data = (state_q == ST_SHIFT) && shreg_q[DATA_WIDTH-1];
  assign o_ser_eof  = (state_q == ST_SHIFT) && (cnt_q == '0);
`endif

endmodule
